// File: rtl/amp_i2c_master_if.sv
// rtl/amp_i2c_master_if.sv - command/response and I2C pad bundle for amp_i2c_master
interface amp_i2c_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rnw;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_nack;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       amp_i2c_scl;
  logic       amp_i2c_sdai;
  logic       amp_i2c_sdao;
  logic       amp_i2c_scli;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_dev_addr, cmd_reg_addr, cmd_wdata,
    input  amp_i2c_sdai, amp_i2c_scli,
    output cmd_ready, rsp_valid, rsp_nack, rsp_rdata, busy,
    output amp_i2c_scl, amp_i2c_sdao
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_dev_addr, cmd_reg_addr, cmd_wdata,
    output amp_i2c_sdai, amp_i2c_scli,
    input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata, busy,
    input  amp_i2c_scl, amp_i2c_sdao
  );
endinterface

// File: rtl/amp_i2c_master.sv
// rtl/amp_i2c_master.sv - byte-oriented I2C register read/write master
// Optional slave clock stretching on SCL readback: define AMP_I2C_STRETCH_EN.
module amp_i2c_master #(
  parameter int CLK_DIV = 67
) (
  input  logic              clk,
  input  logic              resetb,
  amp_i2c_master_if.master  bus
);
  localparam int QW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV);

  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, ACK_CHK, RESTART, RX_BYTE, MACK, STOP, DONE
  } state_t;

  state_t          state, state_nx;
  logic [QW-1:0]   qcnt;
  logic [1:0]      phase;
  logic [2:0]      bit_cnt;
  logic [1:0]      tx_idx;
  logic            rnw_r;
  logic [6:0]      dev_r;
  logic [7:0]      reg_r, wdata_r, tx_sh, rx_sh, rdata_r;
  logic            ack_s, nack_r;
  logic            active, hold, tick, sample, bit_end;
  logic            scl_c, sda_c;

  assign active = (state != IDLE) && (state != DONE);

`ifdef AMP_I2C_STRETCH_EN
  // Freeze at the first cycle of q2 until the pad really reads high.
  assign hold = active && (phase == 2'd2) && (qcnt == '0) && !bus.amp_i2c_scli;
`else
  logic unused_scli;
  assign unused_scli = bus.amp_i2c_scli;
  assign hold        = 1'b0;
`endif

  assign tick    = active && (qcnt == QMAX) && !hold;
  assign sample  = tick && (phase == 2'd2);
  assign bit_end = tick && (phase == 2'd3);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state   <= IDLE;
      qcnt    <= '0;
      phase   <= 2'd0;
      bit_cnt <= 3'd0;
      tx_idx  <= 2'd0;
      rnw_r   <= 1'b0;
      dev_r   <= 7'd0;
      reg_r   <= 8'd0;
      wdata_r <= 8'd0;
      tx_sh   <= 8'd0;
      rx_sh   <= 8'd0;
      rdata_r <= 8'd0;
      ack_s   <= 1'b0;
      nack_r  <= 1'b0;
    end else begin
      state <= state_nx;
      if (!active) begin
        qcnt  <= '0;
        phase <= 2'd0;
      end else if (!hold) begin
        qcnt <= tick ? '0 : qcnt + QW'(1);
        if (tick) phase <= phase + 2'd1;
      end
      if (state == IDLE && bus.cmd_valid) begin
        rnw_r   <= bus.cmd_rnw;
        dev_r   <= bus.cmd_dev_addr;
        reg_r   <= bus.cmd_reg_addr;
        wdata_r <= bus.cmd_wdata;
        tx_sh   <= {bus.cmd_dev_addr, 1'b0};
        tx_idx  <= 2'd0;
        bit_cnt <= 3'd0;
        nack_r  <= 1'b0;
      end
      if (sample) begin
        ack_s <= bus.amp_i2c_sdai;
        if (state == RX_BYTE) rx_sh <= {rx_sh[6:0], bus.amp_i2c_sdai};
      end
      if (bit_end) begin
        case (state)
          TX_BYTE: begin
            tx_sh   <= {tx_sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_BYTE: bit_cnt <= bit_cnt + 3'd1;
          ACK_CHK: begin
            if (ack_s) begin
              nack_r <= 1'b1;
            end else if (tx_idx == 2'd0) begin
              tx_sh  <= reg_r;
              tx_idx <= 2'd1;
            end else if (tx_idx == 2'd1 && !rnw_r) begin
              tx_sh  <= wdata_r;
              tx_idx <= 2'd2;
            end
          end
          RESTART: begin
            tx_sh  <= {dev_r, 1'b1};
            tx_idx <= 2'd2;
          end
          STOP: if (rnw_r && !nack_r) rdata_r <= rx_sh;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nx = state;
    scl_c    = 1'b1;
    sda_c    = 1'b1;
    case (state)
      IDLE: if (bus.cmd_valid) state_nx = START;
      START: begin
        sda_c = !phase[1];
        if (bit_end) state_nx = TX_BYTE;
      end
      TX_BYTE: begin
        scl_c = phase[1];
        sda_c = tx_sh[7];
        if (bit_end && bit_cnt == 3'd7) state_nx = ACK_CHK;
      end
      ACK_CHK: begin
        scl_c = phase[1];
        if (bit_end) begin
          if (ack_s)                state_nx = STOP;
          else if (tx_idx == 2'd0)  state_nx = TX_BYTE;
          else if (tx_idx == 2'd1)  state_nx = rnw_r ? RESTART : TX_BYTE;
          else                      state_nx = rnw_r ? RX_BYTE : STOP;
        end
      end
      RESTART: begin
        // SCL stays low for q0/q1 so the bus sees SDA high before SCL rises.
        scl_c = phase[1];
        sda_c = (phase != 2'd3);
        if (bit_end) state_nx = TX_BYTE;
      end
      RX_BYTE: begin
        scl_c = phase[1];
        if (bit_end && bit_cnt == 3'd7) state_nx = MACK;
      end
      MACK: begin
        scl_c = phase[1];
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        scl_c = phase[1];
        sda_c = 1'b0;
        if (bit_end) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.amp_i2c_scl  = scl_c;
  assign bus.amp_i2c_sdao = sda_c;
  assign bus.cmd_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.rsp_valid    = (state == DONE);
  assign bus.rsp_nack     = nack_r;
  assign bus.rsp_rdata    = rdata_r;
endmodule

// File: tb/tb_amp_i2c_master.sv
// tb/tb_amp_i2c_master.sv - bench for amp_i2c_master with a behavioural I2C slave on the bus
module tb_amp_i2c_master;
  localparam int CLK_DIV = 3;
  localparam int B = 4 * (CLK_DIV + 1);

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  amp_i2c_master_if bus ();
  amp_i2c_master #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .resetb(resetb), .bus(bus));

  // Slave-side knobs, written by the stimulus and read by the slave model.
  int         nack_at = 3;
  logic [7:0] rd_byte = 8'h00;
  logic       scl_hold = 1'b0;

  // Slave model state, written only by the slave process.
  logic       drive = 1'b1;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       in_frame = 1'b0, rd_mode = 1'b0, pend = 1'b0, mack = 1'b0;
  int         bitn = 0, fbyte = 0, txb = 0;
  int         g_starts = 0, g_stops = 0, g_restarts = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] seen [4];

  assign bus.amp_i2c_sdai = bus.amp_i2c_sdao & drive;
  assign bus.amp_i2c_scli = bus.amp_i2c_scl & ~scl_hold;

  always @(negedge clk) begin
    logic scl_n, sda_n;
    scl_n = bus.amp_i2c_scl;
    sda_n = bus.amp_i2c_sdai;
    if (!resetb) begin
      in_frame = 1'b0; rd_mode = 1'b0; pend = 1'b0; drive = 1'b1; bitn = 0;
    end else if (prev_scl && scl_n && prev_sda && !sda_n) begin
      if (!in_frame) begin txb = 0; mack = 1'b0; end
      else g_restarts++;
      g_starts++;
      in_frame = 1'b1; bitn = 0; fbyte = 0; rd_mode = 1'b0; pend = 1'b0; drive = 1'b1;
    end else if (prev_scl && scl_n && !prev_sda && sda_n) begin
      g_stops++;
      in_frame = 1'b0; rd_mode = 1'b0; drive = 1'b1; bitn = 0;
    end else if (in_frame && !prev_scl && scl_n) begin
      if (bitn < 8) shreg = {shreg[6:0], sda_n};
      else if (rd_mode) mack = sda_n;
      bitn++;
    end else if (in_frame && prev_scl && !scl_n) begin
      if (bitn == 8) begin
        if (rd_mode) drive = 1'b1;
        else begin
          if (txb < 4) seen[txb] = shreg;
          drive = (txb == nack_at);
          pend  = (fbyte == 0) && shreg[0] && (txb != nack_at);
          txb++; fbyte++;
        end
      end else if (bitn == 9) begin
        bitn = 0;
        if (pend) begin rd_mode = 1'b1; pend = 1'b0; drive = rd_byte[7]; end
        else drive = 1'b1;
      end else if (rd_mode && bitn >= 1 && bitn <= 7) begin
        drive = rd_byte[7 - bitn];
      end
    end
    prev_scl = scl_n;
    prev_sda = sda_n;
  end

  typedef struct {
    logic       rnw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    int         nack_at;
    logic [7:0] slave_rd;
    int         exp_lat;
    logic       exp_nack;
    logic [7:0] exp_rdata;
    int         exp_nbytes;
    logic [7:0] exp_b [3];
  } vec_t;

  vec_t tbl [$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                     input int na, input logic [7:0] srd, input int lat, input logic nk,
                     input logic [7:0] rd, input int nb, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2);
    vec_t v;
    v.rnw = rnw; v.dev = dev; v.rg = rg; v.wd = wd; v.nack_at = na; v.slave_rd = srd;
    v.exp_lat = lat; v.exp_nack = nk; v.exp_rdata = rd; v.exp_nbytes = nb;
    v.exp_b[0] = b0; v.exp_b[1] = b1; v.exp_b[2] = b2;
    tbl.push_back(v);
  endtask

  // Transaction-level reference: bit count is START + 9 per byte + RESTART + read byte/MACK + STOP.
  function automatic vec_t model(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                                 input logic [7:0] wd, input int na, input logic [7:0] srd,
                                 input logic [7:0] prev_rd);
    vec_t v;
    int   bits;
    logic stopped;
    v.rnw = rnw; v.dev = dev; v.rg = rg; v.wd = wd; v.nack_at = na; v.slave_rd = srd;
    v.exp_b[0] = {dev, 1'b0};
    v.exp_b[1] = rg;
    v.exp_b[2] = rnw ? {dev, 1'b1} : wd;
    bits = 1; stopped = 1'b0; v.exp_nbytes = 3;
    for (int k = 0; k < 3; k++) begin
      if (!stopped) begin
        if (rnw && k == 2) bits += 1;
        bits += 9;
        if (k == na) begin stopped = 1'b1; v.exp_nbytes = k + 1; end
      end
    end
    if (rnw && !stopped) bits += 9;
    bits += 1;
    v.exp_nack  = stopped;
    v.exp_lat   = bits * B + 1;
    v.exp_rdata = (rnw && !stopped) ? srd : prev_rd;
    return v;
  endfunction

  task automatic issue(input logic rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    @(posedge clk); #1;
    chk("accept_ready", bus.cmd_ready, 1);
    bus.cmd_rnw = rnw; bus.cmd_dev_addr = dev; bus.cmd_reg_addr = rg; bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles required within 3000", lat);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int extra);
    int lat, st0, rs0;
    nack_at = v.nack_at; rd_byte = v.slave_rd;
    st0 = g_stops; rs0 = g_restarts;
    issue(v.rnw, v.dev, v.rg, v.wd);
    wait_rsp(lat);
    chk({tag, "_lat"}, lat, v.exp_lat + extra);
    chk({tag, "_nack"}, bus.rsp_nack, v.exp_nack);
    chk({tag, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, bus.rsp_valid, 0);
    chk({tag, "_stops"}, g_stops - st0, 1);
    chk({tag, "_restarts"}, g_restarts - rs0, (v.rnw && v.nack_at >= 2) ? 1 : 0);
    chk({tag, "_nbytes"}, txb, v.exp_nbytes);
    for (int k = 0; k < v.exp_nbytes; k++) chk($sformatf("%s_byte%0d", tag, k), seen[k], v.exp_b[k]);
    if (v.rnw && !v.exp_nack) chk({tag, "_mack"}, mack, 1);
  endtask

  initial begin
    int         lat, s0;
    logic [7:0] model_rd;
    vec_t       v;
    bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_dev_addr = 7'd0;
    bus.cmd_reg_addr = 8'd0; bus.cmd_wdata = 8'd0;
    repeat (3) @(posedge clk);
    #1 resetb = 1'b1;
    chk("rst_scl", bus.amp_i2c_scl, 1);
    chk("rst_sdao", bus.amp_i2c_sdao, 1);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_nack", bus.rsp_nack, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);

    add(0, 7'h20, 8'h03, 8'hA5, 3, 8'h00, 465, 0, 8'h00, 3, 8'h40, 8'h03, 8'hA5);
    add(1, 7'h20, 8'h7E, 8'h00, 3, 8'h5C, 625, 0, 8'h5C, 3, 8'h40, 8'h7E, 8'h41);
    add(0, 7'h20, 8'h03, 8'hA5, 0, 8'h00, 177, 1, 8'h5C, 1, 8'h40, 8'h00, 8'h00);
    add(1, 7'h55, 8'h10, 8'h00, 1, 8'h99, 321, 1, 8'h5C, 2, 8'hAA, 8'h10, 8'h00);
    add(1, 7'h7F, 8'hFF, 8'h00, 2, 8'h99, 481, 1, 8'h5C, 3, 8'hFE, 8'hFF, 8'hFF);
    add(1, 7'h01, 8'h00, 8'h00, 3, 8'h81, 625, 0, 8'h81, 3, 8'h02, 8'h00, 8'h03);
    add(0, 7'h3C, 8'h42, 8'h00, 2, 8'h00, 465, 1, 8'h81, 3, 8'h78, 8'h42, 8'h00);
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i), 0);
    model_rd = 8'h81;

    for (int i = 0; i < 10; i++) begin
      v = model($urandom_range(0, 1), 7'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 5), 8'($urandom), model_rd);
      model_rd = v.exp_rdata;
      run_vec(v, $sformatf("rnd%0d", i), 0);
    end

    // Reset pulse during bit 4 of the register byte.
    nack_at = 3;
    issue(0, 7'h12, 8'h34, 8'h56);
    repeat (229) @(posedge clk);
    #1 resetb = 1'b0;
    @(posedge clk); #1 resetb = 1'b1;
    chk("midrst_scl", bus.amp_i2c_scl, 1);
    chk("midrst_sdao", bus.amp_i2c_sdao, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.cmd_ready, 1);
    model_rd = 8'h00;
    run_vec(model(0, 7'h12, 8'h34, 8'h56, 3, 8'h00, model_rd), "after_rst", 0);

    // Back-to-back with cmd_valid held high.
    nack_at = 3; s0 = g_starts;
    @(posedge clk); #1;
    bus.cmd_rnw = 1'b0; bus.cmd_dev_addr = 7'h11; bus.cmd_reg_addr = 8'h22; bus.cmd_wdata = 8'h33;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    wait_rsp(lat);
    chk("b2b_lat1", lat, 465);
    chk("b2b_ready_at_rsp", bus.cmd_ready, 0);
    chk("b2b_starts1", g_starts - s0, 1);
    @(posedge clk); #1;
    chk("b2b_ready_after", bus.cmd_ready, 1);
    bus.cmd_dev_addr = 7'h44; bus.cmd_reg_addr = 8'h55; bus.cmd_wdata = 8'h66;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("b2b_busy2", bus.busy, 1);
    wait_rsp(lat);
    chk("b2b_lat2", lat, 465);
    @(posedge clk); #1;
    chk("b2b_starts2", g_starts - s0, 2);
    chk("b2b_byte0", seen[0], 8'h88);
    chk("b2b_byte2", seen[2], 8'h66);

`ifdef AMP_I2C_STRETCH_EN
    // Slave holds SCL low for 50 cycles at the start of q2 in the register-byte ACK bit.
    v = model(0, 7'h2A, 8'h0F, 8'hC3, 3, 8'h00, model_rd);
    fork
      run_vec(v, "stretch", 50);
      begin
        @(posedge clk); @(posedge clk);
        repeat (1 + 18 * B + 2 * (CLK_DIV + 1) - 2) @(posedge clk);
        #1 scl_hold = 1'b1;
        repeat (50) @(posedge clk);
        #1 scl_hold = 1'b0;
      end
    join
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/amp_i2c_master.md
Name: amp_i2c_master

Overview:
Byte-oriented I2C master that drives the amplifier control bus (amp_i2c_scl / amp_i2c_sdai / amp_i2c_sdao). It is the initiator counterpart of the existing I2C slave register interface. It accepts one register-write or register-read command at a time from the system control logic. It then runs a complete START…STOP transaction and returns read data and an ACK/NACK status. Open-drain SDA pad muxing stays in the FPGA wrapper: sdao=0 drives low, sdao=1 releases.

Parameters:
CLK_DIV, 67, quarter-bit period minus 1 in clk cycles. One SCL bit lasts 4*(CLK_DIV+1) cycles; the default gives about 100 kHz at 27 MHz.

Ports:
clk  in  1  system clock
resetb  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when idle; a command is accepted when cmd_valid && cmd_ready
cmd_rnw  in  1  1 = register read, 0 = register write
cmd_dev_addr  in  7  7-bit device address
cmd_reg_addr  in  8  register address
cmd_wdata  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse at transaction end
rsp_nack  out  1  valid with rsp_valid; 1 = a slave NACK aborted the transaction
rsp_rdata  out  8  read byte; held until the next read completes
busy  out  1  transaction in progress
amp_i2c_scl  out  1  SCL, push-pull
amp_i2c_sdai  in  1  SDA pad input
amp_i2c_sdao  out  1  SDA open-drain control
amp_i2c_scli  in  1  SCL pad readback (used only with AMP_I2C_STRETCH_EN)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (resetb sampled on clk rising edge).
- Reset values:
  - amp_i2c_scl=1, amp_i2c_sdao=1, cmd_ready=1, busy=0
  - rsp_valid=0, rsp_nack=0, rsp_rdata=8'h00
  - FSM=IDLE, all counters 0
- Reset mid-transaction: the outputs above take effect on the next edge. SCL and SDA are released with no STOP generated.
- Command acceptance: the command fields are latched on the accept cycle. On the next cycle cmd_ready=0 and busy=1.
- Quarter counter: counts 0..CLK_DIV, and a phase tick fires on wrap. There are 4 phases per bit (q0..q3):
  - q0, q1: SCL low
  - q2, q3: SCL high
  - SDA changes only at the start of q0
  - SDA is sampled at the end of q2
- FSM states and sequence:
  - IDLE → START: SDA falls at q2 with SCL high; SCL falls at q3→q0.
  - START → TX_BYTE: 8 bits, MSB first.
  - TX_BYTE → ACK_CHK: SDA released; the slave ACK is sampled.
  - Write sequence: START, {dev,0}, ACK, reg, ACK, wdata, ACK, STOP.
  - Read sequence: START, {dev,0}, ACK, reg, ACK, RESTART, {dev,1}, ACK, RX_BYTE (8 bits sampled MSB first), MACK (master drives NACK=1), STOP.
  - RESTART: one bit time; SDA is released in q0/q1, SCL rises in q2, SDA falls in q3.
  - STOP: SDA low in q0/q1, SCL high from q2, SDA released at the end of q3.
  - DONE: rsp_valid=1 for one cycle, then → IDLE with cmd_ready=1 on the following cycle.
- NACK (sdai=1 at any ACK_CHK): go directly to STOP, then DONE with rsp_nack=1. rsp_rdata is left unchanged.
- Latency, counted in bit-times B=4*(CLK_DIV+1) cycles from the accept cycle to rsp_valid:
  - write: 29·B + 1
  - read: 39·B + 1
  - NACK on device address: 11·B + 1
- cmd_valid while busy is ignored; there is no queue.
- A command presented on the same cycle rsp_valid fires is not accepted. The earliest accept is the cycle after rsp_valid.

Optional Feature:
AMP_I2C_STRETCH_EN
- Defined: on entering q2 the quarter counter holds while amp_i2c_scli=0, so the q2 phase starts only when SCL reads high. This allows slave clock stretching of any length, with no timeout.
- Undefined: amp_i2c_scli is ignored and timing is fixed as above.

Test Plan:
- Write, slave ACKs all (CLK_DIV=3, B=16): dev=0x20, reg=0x03, wdata=0xA5 → SDA bytes 0x40, 0x03, 0xA5; rsp_valid at cycle 465 after accept; rsp_nack=0.
- Read, slave returns 0x5C: dev=0x20, reg=0x7E → bytes 0x40, 0x7E, RESTART, 0x41; master NACK then STOP; rsp_rdata=0x5C; rsp_valid at cycle 625; rsp_nack=0.
- No slave (sdai held 1): write command → STOP right after the first ACK slot; rsp_nack=1 at cycle 177; rsp_rdata unchanged.
- Reset mid-byte: resetb=0 for 1 cycle during bit 4 of the reg byte → next cycle scl=1, sdao=1, busy=0, cmd_ready=1. A following write completes normally.
- Back-to-back: cmd_valid held high with two writes → second accepted exactly 1 cycle after the first rsp_valid; no START is issued while busy.
- AMP_I2C_STRETCH_EN: scli held low for 50 cycles at the ACK bit of the reg byte → q2 is delayed by 50 cycles, total latency is +50 cycles, and data is correct.
